inst_fetch_unit: RTL and testbench

//  Requester side of the instruction-memory req/ready interface (mem_simulator is the responder).

---
 rtl/inst_fetch_unit_if.sv | 37 +++
 rtl/inst_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request/response,
// backend redirect, and the decode-side pack stream.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int PACK_W = 128
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [PACK_W-1:0] mem_data;
  logic              mem_valid;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;

  logic              out_valid;
  logic              out_ready;
  logic [PACK_W-1:0] out_pack;
  logic [ADDR_W-1:0] out_addr;
  logic              out_fault;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_data, mem_valid,
    input  redirect_valid, redirect_addr,
    output out_valid, out_pack, out_addr, out_fault,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_data, mem_valid,
    output redirect_valid, redirect_addr,
    input  out_valid, out_pack, out_addr, out_fault,
    output out_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one outstanding pack request at a time,
// packs buffered in a small FIFO toward decode.
module inst_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int PACK_W     = 128,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clock,
  input logic reset,
  inst_fetch_unit_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_DRAIN, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [PACK_W-1:0] pack_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] paddr_q [FIFO_DEPTH];
  logic              fault_q [FIFO_DEPTH];

  logic push, pop, flush, head_v;

  assign head_v = (cnt_q != '0);
  assign pop    = head_v && bus.out_ready;
  assign flush  = bus.redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_addr;
        end else if (cnt_q < DEPTH_C) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_addr;
          if (bus.mem_ready) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (bus.mem_ready) begin
          push = 1'b1;
          if (bus.mem_valid) begin
            pc_d = pc_q + 1'b1;
            // room left after this push: keep streaming
            if (cnt_q < DEPTH_C - 1'b1) begin
              addr_d = pc_q + 1'b1;
            end else begin
              req_d   = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            req_d   = 1'b0;
            state_d = S_HALT;
          end
        end
      end
      S_DRAIN: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_addr;
        end
        if (bus.mem_ready) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_addr;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      pack_q[wr_q]  <= bus.mem_data;
      paddr_q[wr_q] <= addr_q;
      fault_q[wr_q] <= !bus.mem_valid;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = head_v;
  assign bus.out_pack  = head_v ? pack_q[rd_q]  : '0;
  assign bus.out_addr  = head_v ? paddr_q[rd_q] : '0;
  assign bus.out_fault = head_v ? fault_q[rd_q] : 1'b0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: modelled memory responder,
// directed scenarios and a randomized stream check.
module tb_inst_fetch_unit;

  localparam int MEMSZ = 40;
  localparam int LOGN  = 8192;

  logic clock;
  logic reset;

  inst_fetch_unit_if #(.ADDR_W(32), .PACK_W(128)) bus ();

  inst_fetch_unit #(
    .ADDR_W(32), .PACK_W(128), .FIFO_DEPTH(4), .RESET_PC(32'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks, errors;

  // responder controls (written by tests)
  bit   resp_en;
  int   lat;
  logic force_ready, force_valid;

  // responder state and logs (written only by responder)
  bit          busy;
  int          cnt;
  logic [31:0] laddr;
  int          req_n, resp_n, unstable;
  logic [31:0] req_log [LOGN];

  // monitor logs (written only by monitor)
  int           pop_n, ep_n;
  logic [31:0]  pop_addr  [LOGN];
  logic [127:0] pop_pack  [LOGN];
  logic         pop_fault [LOGN];
  int           pop_ep    [LOGN];
  logic [31:0]  ep_start  [LOGN];

  function automatic logic [127:0] pack_fn(input logic [31:0] a);
    return {a * 32'h9E3779B9, ~a, a ^ 32'hA5A5A5A5, a + 32'd7};
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (!resp_en) begin
      busy = 1'b0;
      bus.mem_ready = force_ready;
      bus.mem_valid = force_valid;
      bus.mem_data  = pack_fn(bus.mem_addr);
    end else begin
      bus.mem_ready = 1'b0;
      if (reset) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          if (!bus.mem_req || bus.mem_addr !== laddr) unstable++;
        end else if (bus.mem_req) begin
          busy  = 1'b1;
          laddr = bus.mem_addr;
          cnt   = lat;
          if (req_n < LOGN) req_log[req_n] = bus.mem_addr;
          req_n++;
        end
        if (busy) begin
          if (cnt <= 1) begin
            bus.mem_ready = 1'b1;
            bus.mem_valid = (laddr < MEMSZ);
            bus.mem_data  = pack_fn(laddr);
            busy = 1'b0;
            resp_n++;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset || bus.redirect_valid) begin
      ep_n++;
      if (ep_n < LOGN)
        ep_start[ep_n] = reset ? 32'd0 : bus.redirect_addr;
    end else if (bus.out_valid && bus.out_ready) begin
      if (pop_n < LOGN) begin
        pop_addr[pop_n]  = bus.out_addr;
        pop_pack[pop_n]  = bus.out_pack;
        pop_fault[pop_n] = bus.out_fault;
        pop_ep[pop_n]    = ep_n;
      end
      pop_n++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    resp_en = 1'b1;
    lat = 1;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick(2);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_req: req=%b addr=%h, required 0/0",
               bus.mem_req, bus.mem_addr);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b fault=%b, required 0/0",
               bus.out_valid, bus.out_fault);
    end
    checks++;
    if (bus.out_pack !== '0 || bus.out_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: pack=%h addr=%h, required 0",
               bus.out_pack, bus.out_addr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, required 1/0",
               bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_stream;
    int r0, p0;
    bit got;
    lat = 3;
    bus.out_ready = 1'b1;
    do_reset();
    r0 = req_n;
    p0 = pop_n;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      #2;
      if (bus.mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL stream_ready: no mem_ready in 30 cycles, required one");
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_early: out_valid=%b at ready, required 0",
               bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'd0 ||
        bus.out_pack !== pack_fn(32'd0)) begin
      errors++;
      $display("FAIL stream_latency: valid=%b addr=%h, required 1/0",
               bus.out_valid, bus.out_addr);
    end
    tick(40);
    checks++;
    if (req_n - r0 < 3 || pop_n - p0 < 3) begin
      errors++;
      $display("FAIL stream_count: reqs=%0d pops=%0d, required >=3",
               req_n - r0, pop_n - p0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (req_log[r0+k] !== 32'(k) || pop_addr[p0+k] !== 32'(k) ||
            pop_pack[p0+k] !== pack_fn(32'(k))) begin
          errors++;
          $display("FAIL stream_seq%0d: req=%h pop=%h, required %0d",
                   k, req_log[r0+k], pop_addr[p0+k], k);
        end
      end
    end
  endtask

  task automatic test_credit;
    int r0, s0, p0;
    lat = 2;
    bus.out_ready = 1'b0;
    do_reset();
    r0 = req_n;
    s0 = resp_n;
    p0 = pop_n;
    tick(60);
    checks++;
    if (resp_n - s0 != 4 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL credit_full: resps=%0d req=%b, required 4/0",
               resp_n - s0, bus.mem_req);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'd0) begin
      errors++;
      $display("FAIL credit_head: valid=%b addr=%h, required 1/0",
               bus.out_valid, bus.out_addr);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick(40);
    checks++;
    if (resp_n - s0 != 5 || req_n - r0 != 5 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL credit_one: resps=%0d reqs=%0d req=%b, required 5/5/0",
               resp_n - s0, req_n - r0, bus.mem_req);
    end
    checks++;
    if (req_log[r0+4] !== 32'd4 || pop_n - p0 != 1 ||
        pop_addr[p0] !== 32'd0) begin
      errors++;
      $display("FAIL credit_addr: req4=%h pops=%0d, required 4/1",
               req_log[r0+4], pop_n - p0);
    end
  endtask

  task automatic test_redirect;
    int r0, p0, n5;
    bit got;
    lat = 8;
    bus.out_ready = 1'b1;
    do_reset();
    r0 = req_n;
    p0 = pop_n;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_n - r0 >= 6) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || req_log[r0+5] !== 32'd5) begin
      errors++;
      $display("FAIL redir_setup: reached=%b addr=%h, required 1/5",
               got, req_log[r0+5]);
    end
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h10;
    tick();
    bus.redirect_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd5) begin
        errors++;
        $display("FAIL redir_hold: req=%b addr=%h, required 1/5",
                 bus.mem_req, bus.mem_addr);
      end
      if (bus.mem_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL redir_drain: no ready in 20 cycles, required one");
    end
    tick(40);
    n5 = 0;
    for (int i = p0; i < pop_n; i++)
      if (pop_addr[i] == 32'd5) n5++;
    checks++;
    if (n5 != 0 || req_log[r0+6] !== 32'h10) begin
      errors++;
      $display("FAIL redir_drop: pops_of_5=%0d next_req=%h, required 0/10",
               n5, req_log[r0+6]);
    end
    checks++;
    if (pop_n - p0 < 6 || pop_addr[p0+5] !== 32'h10) begin
      errors++;
      $display("FAIL redir_first: pops=%0d addr=%h, required >=6/10",
               pop_n - p0, pop_addr[p0+5]);
    end
  endtask

  task automatic test_fault;
    int r0, p0;
    lat = 2;
    bus.out_ready = 1'b1;
    do_reset();
    r0 = req_n;
    p0 = pop_n;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'd39;
    tick();
    bus.redirect_valid = 1'b0;
    tick(40);
    checks++;
    if (pop_n - p0 != 2 || req_n - r0 != 2 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_halt: pops=%0d reqs=%0d req=%b, required 2/2/0",
               pop_n - p0, req_n - r0, bus.mem_req);
    end
    checks++;
    if (pop_addr[p0] !== 32'd39 || pop_fault[p0] !== 1'b0) begin
      errors++;
      $display("FAIL fault_39: addr=%h fault=%b, required 27/0",
               pop_addr[p0], pop_fault[p0]);
    end
    checks++;
    if (pop_addr[p0+1] !== 32'd40 || pop_fault[p0+1] !== 1'b1) begin
      errors++;
      $display("FAIL fault_40: addr=%h fault=%b, required 28/1",
               pop_addr[p0+1], pop_fault[p0+1]);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'd0;
    tick();
    bus.redirect_valid = 1'b0;
    tick(20);
    checks++;
    if (req_log[r0+2] !== 32'd0 || pop_n - p0 < 3 ||
        pop_addr[p0+2] !== 32'd0 || pop_fault[p0+2] !== 1'b0) begin
      errors++;
      $display("FAIL fault_restart: req=%h pop=%h, required 0/0",
               req_log[r0+2], pop_addr[p0+2]);
    end
  endtask

  task automatic test_same_cycle;
    resp_en = 1'b0;
    force_ready = 1'b0;
    force_valid = 1'b1;
    bus.out_ready = 1'b0;
    do_reset();
    tick();
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'd0 ||
        bus.mem_addr !== 32'd1 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL same_setup: valid=%b oaddr=%h maddr=%h, required 1/0/1",
               bus.out_valid, bus.out_addr, bus.mem_addr);
    end
    force_ready = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h20;
    tick();
    force_ready = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL same_flush: valid=%b req=%b, required 0/0",
               bus.out_valid, bus.mem_req);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20 ||
        bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_next: req=%b addr=%h valid=%b, required 1/20/0",
               bus.mem_req, bus.mem_addr, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid;
    resp_en = 1'b0;
    force_ready = 1'b0;
    force_valid = 1'b1;
    bus.out_ready = 1'b0;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'd7;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_addr !== 32'd8) begin
      errors++;
      $display("FAIL rmid_setup: valid=%b addr=%h, required 1/8",
               bus.out_valid, bus.mem_addr);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'd0 ||
        bus.out_valid !== 1'b0 || bus.out_addr !== 32'd0 ||
        bus.out_pack !== '0 || bus.out_fault !== 1'b0) begin
      errors++;
      $display("FAIL rmid_zero: req=%b addr=%h valid=%b, required 0/0/0",
               bus.mem_req, bus.mem_addr, bus.out_valid);
    end
    reset = 1'b0;
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd0 ||
        bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stray: req=%b addr=%h valid=%b, required 1/0/0",
               bus.mem_req, bus.mem_addr, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL rmid_hold: req=%b addr=%h, required 1/0",
               bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_random;
    int p0, prev, bad;
    logic [31:0] exp;
    bit faulted;
    resp_en = 1'b1;
    lat = 1;
    do_reset();
    p0 = pop_n;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom % 4) != 0;
      lat = $urandom_range(1, 4);
      if ($urandom % 40 == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = $urandom_range(0, 44);
      end else begin
        bus.redirect_valid = 1'b0;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(20);
    checks++;
    if (pop_n - p0 < 200 || pop_n > LOGN) begin
      errors++;
      $display("FAIL rand_progress: pops=%0d, required >=200", pop_n - p0);
    end
    // each run since a redirect must pop consecutive packs from its target
    prev = -1;
    exp = 32'd0;
    faulted = 1'b0;
    bad = 0;
    for (int i = p0; i < pop_n && i < LOGN; i++) begin
      if (pop_ep[i] != prev) begin
        prev = pop_ep[i];
        exp = ep_start[prev];
        faulted = 1'b0;
      end
      checks++;
      if (faulted || pop_addr[i] !== exp || pop_pack[i] !== pack_fn(exp) ||
          pop_fault[i] !== (exp >= MEMSZ)) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_pop%0d: addr=%h fault=%b, required %h/%b",
                   i, pop_addr[i], pop_fault[i], exp, exp >= MEMSZ);
        bad++;
      end
      faulted = pop_fault[i];
      exp = exp + 32'd1;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL addr_stable: changes=%0d, required 0", unstable);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    resp_en = 1'b1;
    lat = 1;
    force_ready = 1'b0;
    force_valid = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = 32'd0;
    test_reset();
    test_stream();
    test_credit();
    test_redirect();
    test_fault();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
